flowstate_hazard_ctl: RTL and testbench

- Joins the packet-metadata stream and the flow-state match-result stream, one pair per transfer, into a single registered output beat.
- Tags each beat with which of the last HIST_DEPTH accepted data-tagged flow addresses it collides with.
- Sits in the reliable-TX path between the flow-state lookup and the flow-state update stage. The update stage uses the selector to forward in-flight state instead of stale table values.
- Successor to the fixed 3-deep address tracker: depth is parametrised, and a write-back port retires history entries once the update stage has committed them.

---
 rtl/flowstate_hazard_ctl.sv | 130 +++++++++++++
 tb/tb_flowstate_hazard_ctl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/flowstate_hazard_ctl.sv
// Joins the metadata and flow-state match streams into one registered beat, tagged with in-flight address hazards.
// Optional per-slot hazard counters are built when FLOWSTATE_HAZARD_STAT_EN is defined.
module flowstate_hazard_ctl #(
  parameter int PKT_METADATA_WIDTH = 274,
  parameter int FLOWSTATE_WIDTH    = 33,
  parameter int ADDR_WIDTH         = 10,
  parameter int HIST_DEPTH         = 3,
  parameter int DAT_TAG_BIT        = 246,
  localparam int SEL_W             = $clog2(HIST_DEPTH + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [PKT_METADATA_WIDTH-1:0] s_pkt_metadata_info,
  input  logic                          s_pkt_metadata_valid,
  output logic                          s_pkt_metadata_ready,
  input  logic                          s_mat_hit,
  input  logic [FLOWSTATE_WIDTH-1:0]    s_mat_value,
  input  logic [ADDR_WIDTH-1:0]         s_mat_addr,
  input  logic                          s_mat_valid,
  output logic                          s_mat_ready,
  input  logic [ADDR_WIDTH-1:0]         s_wb_addr,
  input  logic                          s_wb_valid,
  output logic [PKT_METADATA_WIDTH-1:0] m_pkt_metadata_info,
  output logic [SEL_W-1:0]              m_pkt_metadata_match_sel,
  output logic                          m_pkt_metadata_mat_hit,
  output logic [FLOWSTATE_WIDTH-1:0]    m_pkt_metadata_mat_value,
  output logic [ADDR_WIDTH-1:0]         m_pkt_metadata_mat_addr,
  output logic                          m_pkt_metadata_valid,
  input  logic                          m_pkt_metadata_ready,
  output logic [16*HIST_DEPTH-1:0]      m_stat_hazard_cnt
);

  logic                                  accept;
  logic                                  valid_q;
  logic [PKT_METADATA_WIDTH-1:0]         info_q;
  logic [SEL_W-1:0]                      sel_q;
  logic                                  hit_q;
  logic [FLOWSTATE_WIDTH-1:0]            value_q;
  logic [ADDR_WIDTH-1:0]                 addr_q;
  logic [SEL_W-1:0]                      match_sel;
  logic [HIST_DEPTH-1:0]                 hist_v_q, hist_v_d, hist_v_clr;
  logic [HIST_DEPTH-1:0][ADDR_WIDTH-1:0] hist_addr_q, hist_addr_d;

  assign accept = (~valid_q | m_pkt_metadata_ready) & s_pkt_metadata_valid & s_mat_valid;
  assign s_pkt_metadata_ready = accept;
  assign s_mat_ready          = accept;

  // Write-back retires committed entries before both the match and the shift see them.
  for (genvar gi = 0; gi < HIST_DEPTH; gi++) begin : g_clr
    assign hist_v_clr[gi] = hist_v_q[gi] & ~(s_wb_valid & (hist_addr_q[gi] == s_wb_addr));
  end

  // Scan oldest to youngest so the youngest matching entry has the final word.
  always_comb begin
    match_sel = '0;
    for (int k = HIST_DEPTH - 1; k >= 0; k--) begin
      if (hist_v_clr[k] && (hist_addr_q[k] == s_mat_addr)) match_sel = SEL_W'(k + 1);
    end
  end

  always_comb begin
    hist_v_d    = hist_v_clr;
    hist_addr_d = hist_addr_q;
    if (accept) begin
      hist_v_d[0]    = s_mat_hit & s_pkt_metadata_info[DAT_TAG_BIT];
      hist_addr_d[0] = s_mat_addr;
      for (int k = 1; k < HIST_DEPTH; k++) begin
        hist_v_d[k]    = hist_v_clr[k-1];
        hist_addr_d[k] = hist_addr_q[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_v_q    <= '0;
      hist_addr_q <= '0;
      valid_q     <= 1'b0;
      info_q      <= '0;
      sel_q       <= '0;
      hit_q       <= 1'b0;
      value_q     <= '0;
      addr_q      <= '0;
    end else begin
      hist_v_q    <= hist_v_d;
      hist_addr_q <= hist_addr_d;
      if (accept) begin
        valid_q <= 1'b1;
        info_q  <= s_pkt_metadata_info;
        sel_q   <= match_sel;
        hit_q   <= s_mat_hit;
        value_q <= s_mat_value;
        addr_q  <= s_mat_addr;
      end else if (m_pkt_metadata_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign m_pkt_metadata_valid     = valid_q;
  assign m_pkt_metadata_info      = info_q;
  assign m_pkt_metadata_match_sel = sel_q;
  assign m_pkt_metadata_mat_hit   = hit_q;
  assign m_pkt_metadata_mat_value = value_q;
  assign m_pkt_metadata_mat_addr  = addr_q;

`ifdef FLOWSTATE_HAZARD_STAT_EN
  logic [HIST_DEPTH-1:0][15:0] cnt_q, cnt_d;

  // Saturating per-slot hazard counters, slot k counts beats forwarded from entry k.
  always_comb begin
    cnt_d = cnt_q;
    for (int k = 0; k < HIST_DEPTH; k++) begin
      if (accept && (match_sel == SEL_W'(k + 1)) && (cnt_q[k] != 16'hFFFF)) begin
        cnt_d[k] = cnt_q[k] + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign m_stat_hazard_cnt = cnt_q;
`else
  assign m_stat_hazard_cnt = '0;
`endif

endmodule

// File: tb/tb_flowstate_hazard_ctl.sv
// Randomized and directed scoreboard bench for flowstate_hazard_ctl against a queue-based history model.
module tb_flowstate_hazard_ctl;
  localparam int PW = 274;
  localparam int FW = 33;
  localparam int AW = 10;
  localparam int HD = 3;
  localparam int TB = 246;
  localparam int SW = $clog2(HD + 1);
`ifdef FLOWSTATE_HAZARD_STAT_EN
  localparam bit STAT = 1'b1;
`else
  localparam bit STAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [PW-1:0] s_pkt_metadata_info;
  logic s_pkt_metadata_valid, s_pkt_metadata_ready;
  logic s_mat_hit;
  logic [FW-1:0] s_mat_value;
  logic [AW-1:0] s_mat_addr;
  logic s_mat_valid, s_mat_ready;
  logic [AW-1:0] s_wb_addr;
  logic s_wb_valid;
  logic [PW-1:0] m_pkt_metadata_info;
  logic [SW-1:0] m_pkt_metadata_match_sel;
  logic m_pkt_metadata_mat_hit;
  logic [FW-1:0] m_pkt_metadata_mat_value;
  logic [AW-1:0] m_pkt_metadata_mat_addr;
  logic m_pkt_metadata_valid, m_pkt_metadata_ready;
  logic [16*HD-1:0] m_stat_hazard_cnt;

  always #5 clk = ~clk;

  flowstate_hazard_ctl #(
    .PKT_METADATA_WIDTH(PW), .FLOWSTATE_WIDTH(FW), .ADDR_WIDTH(AW),
    .HIST_DEPTH(HD), .DAT_TAG_BIT(TB)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_pkt_metadata_info(s_pkt_metadata_info), .s_pkt_metadata_valid(s_pkt_metadata_valid),
    .s_pkt_metadata_ready(s_pkt_metadata_ready),
    .s_mat_hit(s_mat_hit), .s_mat_value(s_mat_value), .s_mat_addr(s_mat_addr),
    .s_mat_valid(s_mat_valid), .s_mat_ready(s_mat_ready),
    .s_wb_addr(s_wb_addr), .s_wb_valid(s_wb_valid),
    .m_pkt_metadata_info(m_pkt_metadata_info), .m_pkt_metadata_match_sel(m_pkt_metadata_match_sel),
    .m_pkt_metadata_mat_hit(m_pkt_metadata_mat_hit), .m_pkt_metadata_mat_value(m_pkt_metadata_mat_value),
    .m_pkt_metadata_mat_addr(m_pkt_metadata_mat_addr), .m_pkt_metadata_valid(m_pkt_metadata_valid),
    .m_pkt_metadata_ready(m_pkt_metadata_ready), .m_stat_hazard_cnt(m_stat_hazard_cnt)
  );

  typedef struct {
    logic [PW-1:0] info;
    logic [SW-1:0] sel;
    logic          hit;
    logic [FW-1:0] value;
    logic [AW-1:0] addr;
  } beat_t;

  typedef struct packed {
    logic          v;
    logic [AW-1:0] a;
  } hent_t;

  beat_t exp_q[$];
  hent_t hist[$];
  bit    out_full;
  int    cnt[HD];
  int    n_checks = 0;
  int    n_fail = 0;
  logic [16*HD-1:0] exp_stat;
  beat_t mon_e;

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] rmeta(input logic tag);
    logic [PW-1:0] m;
    m = '0;
    for (int i = 0; i < PW; i += 32) m = (m << 32) | PW'($urandom);
    m[TB] = tag;
    return m;
  endfunction

  task automatic model_reset();
    hist = {};
    for (int k = 0; k < HD; k++) hist.push_back('0);
    exp_q.delete();
    out_full = 1'b0;
    for (int k = 0; k < HD; k++) cnt[k] = 0;
  endtask

  // Reference: history as a youngest-first queue; write-back clears, then match, then insert.
  task automatic model_update();
    bit acc;
    int sel;
    acc = (!out_full || m_pkt_metadata_ready) && s_pkt_metadata_valid && s_mat_valid;
    if (s_wb_valid)
      foreach (hist[k]) if (hist[k].v && hist[k].a == s_wb_addr) hist[k].v = 1'b0;
    if (acc) begin
      sel = 0;
      foreach (hist[k]) if (sel == 0 && hist[k].v && hist[k].a == s_mat_addr) sel = k + 1;
      exp_q.push_back('{s_pkt_metadata_info, SW'(sel), s_mat_hit, s_mat_value, s_mat_addr});
      if (sel > 0 && cnt[sel-1] < 65535) cnt[sel-1]++;
      hist.push_front('{s_mat_hit & s_pkt_metadata_info[TB], s_mat_addr});
      void'(hist.pop_back());
    end
    out_full = acc || (out_full && !m_pkt_metadata_ready);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_update();
    #1;
  endtask

  task automatic drive(input bit pv, input bit mv, input logic [AW-1:0] addr, input bit hit,
                       input bit tag, input bit wbv, input logic [AW-1:0] wba, input bit rdy);
    s_pkt_metadata_valid = pv;
    s_mat_valid          = mv;
    s_pkt_metadata_info  = rmeta(tag);
    s_mat_hit            = hit;
    s_mat_value          = FW'({$urandom, $urandom});
    s_mat_addr           = addr;
    s_wb_valid           = wbv;
    s_wb_addr            = wba;
    m_pkt_metadata_ready = rdy;
  endtask

  task automatic beat(input logic [AW-1:0] addr, input bit hit, input bit tag,
                      input bit wbv = 1'b0, input logic [AW-1:0] wba = '0);
    drive(1'b1, 1'b1, addr, hit, tag, wbv, wba, 1'b1);
    tick();
  endtask

  task automatic idle(input int n);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    repeat (n) tick();
  endtask

  // Reset is asserted between edges; outputs must clear without waiting for a clock.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", m_pkt_metadata_valid, 1'b0);
    chk("rst_stat", m_stat_hazard_cnt, '0);
    chk("rst_sel", m_pkt_metadata_match_sel, '0);
    model_reset();
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    tick();
    #2 rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_valid", m_pkt_metadata_valid, out_full);
      chk("s_pkt_ready", s_pkt_metadata_ready,
          (!out_full || m_pkt_metadata_ready) && s_pkt_metadata_valid && s_mat_valid);
      chk("s_mat_ready", s_mat_ready,
          (!out_full || m_pkt_metadata_ready) && s_pkt_metadata_valid && s_mat_valid);
      exp_stat = '0;
      if (STAT) for (int k = 0; k < HD; k++) exp_stat[16*k +: 16] = cnt[k][15:0];
      chk("stat_cnt", m_stat_hazard_cnt, exp_stat);
      if (out_full) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL scoreboard: output valid with no expected beat");
        end else begin
          mon_e = exp_q[0];
          chk("info", m_pkt_metadata_info, mon_e.info);
          chk("match_sel", m_pkt_metadata_match_sel, mon_e.sel);
          chk("mat_hit", m_pkt_metadata_mat_hit, mon_e.hit);
          chk("mat_value", m_pkt_metadata_mat_value, mon_e.value);
          chk("mat_addr", m_pkt_metadata_mat_addr, mon_e.addr);
          if (m_pkt_metadata_ready) begin
            $display("beat addr=%0d sel=%0d hit=%0d", mon_e.addr, mon_e.sel, mon_e.hit);
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    model_reset();
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    repeat (3) tick();
    chk("rst_valid", m_pkt_metadata_valid, 1'b0);
    chk("rst_stat", m_stat_hazard_cnt, '0);
    #2 rst_n = 1'b1;

    beat(5, 1, 1); beat(6, 1, 1); beat(7, 1, 1); beat(5, 1, 1);
    beat(9, 1, 1); beat(9, 1, 1); beat(9, 1, 0); beat(9, 1, 1);
    beat(1, 1, 1); beat(2, 1, 1); beat(3, 1, 1); beat(4, 1, 1); beat(1, 1, 1);
    beat(5, 1, 1); beat(6, 1, 1); beat(5, 1, 1, 1'b1, 5); beat(5, 1, 1);
    beat(8, 0, 1); beat(8, 1, 1); beat(12, 1, 1, 1'b1, 99);
    idle(2);

    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 1'b1, AW'(20 + i), 1'b1, 1'b1, 1'b0, '0, 1'b0);
      tick();
    end
    drive(1'b1, 1'b1, 40, 1'b1, 1'b1, 1'b0, '0, 1'b1);
    tick();
    idle(3);

    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, AW'($urandom_range(0, 7)),
            1'($urandom), 1'($urandom), $urandom_range(0, 3) == 0, AW'($urandom_range(0, 7)),
            $urandom_range(0, 9) < 7);
      tick();
    end
    idle(3);

    if (STAT) begin
      do_reset();
      for (int i = 0; i < 70000; i++) beat(3, 1, 1);
      chk("stat_slot0_sat", m_stat_hazard_cnt[15:0], 16'hFFFF);
      do_reset();
      idle(2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
